// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with tick prescaler, synchronous load, wrap flag
// and a multiplexed active-low 7-segment scan driver. Optional: LEADING_ZERO_BLANK_EN.
module bcd_counter_display #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    ovf,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [4*NUM_DIGITS-1:0]   count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [SW-1:0]             scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]             scan_idx_q, scan_idx_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;

  logic                      tick;
  logic                      scan_last;
  logic [4*NUM_DIGITS-1:0]   load_clean;
  logic [4*NUM_DIGITS-1:0]   inc_vec;
  logic [4*NUM_DIGITS-1:0]   dec_vec;
  logic                      all_nine;
  logic                      all_zero;
  logic [3:0]                cur_dig;
  logic                      carry;
  logic                      borrow;
  logic [3:0]                scan_dig;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign scan_last = (scan_cnt_q == SCAN_LAST);

  // Non-BCD load digits are forced to 0 so the counter never holds A-F.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_load
      assign load_clean[4*gi +: 4] =
        (load_val[4*gi +: 4] > 4'd9) ? 4'd0 : load_val[4*gi +: 4];
    end
  endgenerate

  // Ripple carry/borrow across digits in one cycle; the final chain bit flags a full wrap.
  always_comb begin
    inc_vec = count_q;
    dec_vec = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    cur_dig = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_dig = count_q[4*i +: 4];
      if (carry) begin
        inc_vec[4*i +: 4] = (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
      end
      if (borrow) begin
        dec_vec[4*i +: 4] = (cur_dig == 4'd0) ? 4'd9 : cur_dig - 4'd1;
      end
      carry  = carry  & (cur_dig == 4'd9);
      borrow = borrow & (cur_dig == 4'd0);
    end
    all_nine = carry;
    all_zero = borrow;
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    count_d    = count_q;
    ovf_d      = 1'b0;
    if (load) begin
      count_d    = load_clean;
      tick_cnt_d = '0;
    end else if (tick && en) begin
      if (up_dn) begin
        count_d = inc_vec;
        ovf_d   = all_nine;
      end else begin
        count_d = dec_vec;
        ovf_d   = all_zero;
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_last ? '0 : scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_last) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_comb begin
    scan_dig = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        scan_dig = count_q[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  hz;
  logic                  blank;

  // upper_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    hz         = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hz            = hz & (count_q[4*i +: 4] == 4'd0);
      upper_zero[i] = hz;
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        blank = upper_zero[i];
      end
    end
  end

  assign seg_d = blank ? 7'h7F : seg_decode(scan_dig);
`else
  assign seg_d = seg_decode(scan_dig);
`endif

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_d[gi] = ~(scan_idx_q == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display (TICK_DIV=4, SCAN_DIV=3, NUM_DIGITS=4).
module tb_bcd_counter_display;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int ovf_hits  = 0;
  bit bad_digit = 1'b0;

  bcd_counter_display #(
    .NUM_DIGITS(4),
    .TICK_DIV  (4),
    .SCAN_DIV  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .ovf     (ovf),
    .seg     (seg),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ovf === 1'b1) ovf_hits++;
      for (int d = 0; d < 4; d++) begin
        if (count[4*d +: 4] > 4'd9) bad_digit = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] val);
    load     = 1'b1;
    load_val = val;
    step(1);
    load     = 1'b0;
  endtask

  logic [6:0] seg_tab [4];
  logic [3:0] an_exp;
  logic [3:0] prev_an;
  bit         found;

  initial begin
    seg_tab[0] = 7'b0110000;
    seg_tab[1] = 7'b0100100;
    seg_tab[2] = 7'b1111001;
`ifdef LEADING_ZERO_BLANK_EN
    seg_tab[3] = 7'b1111111;
`else
    seg_tab[3] = 7'b1000000;
`endif

    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 16'h0000;

    // Reset state
    step(2);
    check("rst_count", count, 16'h0000);
    check("rst_ovf",   ovf,   1'b0);
    check("rst_seg",   seg,   7'h7F);
    check("rst_an",    an,    4'hF);
    en = 1'b1; up_dn = 1'b1; rst = 1'b1;
    #2;
    check("rel_an_before_edge", an, 4'hF);

    // First edge after release: digit 0 scanned
    step(1);
    check("first_an",  an,  4'b1110);
    check("first_seg", seg, 7'b1000000);
    step(2);
    check("up_pre_tick", count, 16'h0000);
    step(1);
    check("up_first_tick", count, 16'h0001);
    step(36);
    check("up_ten_ticks", count, 16'h0010);
    check("up_no_hex_digit", bad_digit, 1'b0);

    // Up wrap
    do_load(16'h9998);
    ovf_hits = 0;
    step(4);
    check("wrap_9999", count, 16'h9999);
    check("wrap_no_early_ovf", ovf_hits, 0);
    step(4);
    check("wrap_0000", count, 16'h0000);
    check("wrap_ovf_high", ovf, 1'b1);
    step(1);
    check("wrap_ovf_low", ovf, 1'b0);
    check("wrap_ovf_once", ovf_hits, 1);

    // Down borrow and wrap
    up_dn = 1'b0;
    do_load(16'h1000);
    step(4);
    check("dn_borrow", count, 16'h0999);
    do_load(16'h0000);
    ovf_hits = 0;
    step(4);
    check("dn_wrap", count, 16'h9999);
    check("dn_ovf_high", ovf, 1'b1);
    step(1);
    check("dn_ovf_low", ovf, 1'b0);
    check("dn_ovf_once", ovf_hits, 1);

    // Load on a tick cycle wins, invalid digit forced to 0
    up_dn = 1'b1;
    do_load(16'h0005);
    step(3);
    check("pri_pre", count, 16'h0005);
    do_load(16'h12F4);
    check("pri_load_wins", count, 16'h1204);
    step(3);
    check("pri_hold", count, 16'h1204);
    step(1);
    check("pri_next_tick", count, 16'h1205);

    // Load mid-period restarts the prescaler
    step(1);
    do_load(16'h0042);
    check("restart_load", count, 16'h0042);
    step(3);
    check("restart_no_early_tick", count, 16'h0042);
    step(1);
    check("restart_tick", count, 16'h0043);

    // en=0 across a tick loses that tick
    en = 1'b0;
    step(4);
    check("en_off_hold", count, 16'h0043);
    en = 1'b1;
    step(4);
    check("en_on_no_catchup", count, 16'h0044);
    check("no_hex_digit", bad_digit, 1'b0);

    // Scan and decode
    en = 1'b0;
    do_load(16'h0123);
    step(2);
    found   = 1'b0;
    prev_an = an;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
      prev_an = an;
    end
    check("scan_sync", found, 1'b1);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 3; k++) begin
        if (d != 0 || k != 0) step(1);
        an_exp = 4'b1111 ^ (4'b0001 << d);
        check($sformatf("scan_an_d%0d_k%0d", d, k), an, an_exp);
        check($sformatf("scan_seg_d%0d_k%0d", d, k), seg, seg_tab[d]);
      end
    end
    step(1);
    check("scan_wrap_an", an, 4'b1110);

    // Async reset mid-operation
    do_load(16'h0456);
    step(2);
    check("async_pre", count, 16'h0456);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_count", count, 16'h0000);
    check("async_seg",   seg,   7'h7F);
    check("async_an",    an,    4'hF);
    check("async_ovf",   ovf,   1'b0);
    step(1);
    rst = 1'b1;
    step(2);
    check("async_after_release", count, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
